layer4_fc2: RTL and testbench

- Second fully-connected stage. Sits directly downstream of layer3_fc1 and consumes its 32-bit `out_data`/`out_valid` stream.
- Collects the 32 int8 FC1 activations, packed 4 per word, 8 words per frame.
- Computes 10 int32 logits with one serial MAC, reading weights and biases straight from ROM (no preload copy).
- Streams the logits out, then reports the argmax class.

---
 rtl/layer4_fc2_pkg.sv | 17 +
 rtl/layer4_fc2_argmax.sv | 45 ++++
 rtl/rom_FC2_BIASES.sv | 20 ++
 rtl/rom_FC2_WEIGHTS.sv | 20 ++
 rtl/layer4_fc2.sv | 205 ++++++++++++++++++++
 tb/tb_layer4_fc2.sv | 235 +++++++++++++++++++++++
 6 files changed

// File: rtl/layer4_fc2_pkg.sv
// Shared constants and state encoding for the FC2 layer.
// Address widths match the 320-entry weight ROM and 10-entry bias ROM.
package layer4_fc2_pkg;

    localparam int FC2_IN_DIM  = 32;
    localparam int FC2_OUT_DIM = 10;
    localparam int FC2_ACC_W   = 32;
    localparam int FC2_WADDR_W = 9;
    localparam int FC2_BADDR_W = 4;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } fc2_state_e;

endpackage

// File: rtl/layer4_fc2_argmax.sv
// Running argmax over the emitted logits of one frame.
// Strict greater-than keeps the lower index on ties.
module fc_argmax_tracker
    import layer4_fc2_pkg::*;
#(
    parameter int W     = FC2_ACC_W,
    parameter int IDX_W = FC2_BADDR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic             first_i,
    input  logic [W-1:0]     val_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [IDX_W-1:0] idx_o
);

    logic signed [W-1:0] max_q, max_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                take;

    assign take = valid_i && (first_i || ($signed(val_i) > max_q));

    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        if (take) begin
            max_d = $signed(val_i);
            idx_d = idx_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
            idx_q <= '0;
        end else begin
            max_q <= max_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/rom_FC2_BIASES.sv
// FC2 bias ROM: synchronous read, one cycle of latency.
// Contents are provided by the enclosing environment.
module rom_FC2_BIASES #(
    parameter int    ADDR_WIDTH = 4,
    parameter int    DATA_WIDTH = 8,
    parameter int    DEPTH      = 10,
    parameter string MEM_FILE   = ""
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        q <= mem[addr];
    end

endmodule

// File: rtl/rom_FC2_WEIGHTS.sv
// FC2 weight ROM: synchronous read, one cycle of latency.
// Contents are provided by the enclosing environment.
module rom_FC2_WEIGHTS #(
    parameter int    ADDR_WIDTH = 9,
    parameter int    DATA_WIDTH = 8,
    parameter int    DEPTH      = 320,
    parameter string MEM_FILE   = ""
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        q <= mem[addr];
    end

endmodule

// File: rtl/layer4_fc2.sv
// Second fully-connected layer: 32 int8 activations in, 10 int32 logits
// out through one serial MAC fed straight from ROM, then argmax.
module layer4_fc2
    import layer4_fc2_pkg::*;
#(
    parameter int    IN_DIM     = FC2_IN_DIM,
    parameter int    OUT_DIM    = FC2_OUT_DIM,
    parameter int    ACC_W      = FC2_ACC_W,
    parameter string W_MEM_FILE = "rtl/weights/FC2_WEIGHTS.mem",
    parameter string B_MEM_FILE = "rtl/weights/FC2_BIASES.mem"
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic [3:0]       class_idx,
    output logic             class_valid,
    output logic             drop_err
);

    localparam int NWORDS = IN_DIM / 4;
    localparam int NMAC   = OUT_DIM * IN_DIM;
    localparam int WC_W   = $clog2(NWORDS);
    localparam int I_W    = $clog2(IN_DIM);
    localparam int C_W    = $clog2(NMAC + 2);
    localparam int O_W    = FC2_BADDR_W;

    fc2_state_e        state_q, state_d;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic [C_W-1:0]    cnt_q, cnt_d;
    logic [I_W-1:0]    i_q, i_d;
    logic [O_W-1:0]    o_q, o_d;
    logic [31:0]       word_q [NWORDS];

    logic              mac_vld_q, mac_first_q, mac_last_q;
    logic [I_W-1:0]    mac_i_q;
    logic [O_W-1:0]    mac_o_q;
    logic [ACC_W-1:0]  acc_q, acc_d, base;

    logic [ACC_W-1:0]  out_data_q;
    logic              out_valid_q, out_last_q;
    logic [3:0]        class_idx_q;
    logic              class_valid_q, drop_err_q, in_ready_q;

    logic                   accept, issue, emit, done_d;
    logic [FC2_WADDR_W-1:0] waddr;
    logic [7:0]             w_rd, b_rd;
    logic signed [7:0]      act_s;
    logic signed [15:0]     prod;
    logic [O_W-1:0]         max_idx;

    // in_ready_q is only ever high while collecting
    assign accept = valid_in & in_ready_q;
    assign issue  = (state_q == S_COMPUTE) && (cnt_q < C_W'(NMAC));
    assign emit   = mac_vld_q & mac_last_q;
    assign done_d = (state_d == S_DONE);
    assign waddr  = FC2_WADDR_W'(cnt_q);

    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        cnt_d   = cnt_q;
        i_d     = i_q;
        o_d     = o_q;
        unique case (state_q)
            S_COLLECT: begin
                if (accept) begin
                    if (wc_q == WC_W'(NWORDS - 1)) begin
                        wc_d    = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        wc_d = wc_q + 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                cnt_d = cnt_q + 1'b1;
                if (issue) begin
                    if (i_q == I_W'(IN_DIM - 1)) begin
                        i_d = '0;
                        o_d = o_q + 1'b1;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
                if (cnt_q == C_W'(NMAC + 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    i_d     = '0;
                    o_d     = '0;
                end
            end
            S_DONE:  state_d = S_COLLECT;
            default: state_d = S_COLLECT;
        endcase
    end

    rom_FC2_WEIGHTS #(
        .ADDR_WIDTH (FC2_WADDR_W),
        .DATA_WIDTH (8),
        .DEPTH      (NMAC),
        .MEM_FILE   (W_MEM_FILE)
    ) u_wrom (
        .clk  (clk),
        .addr (waddr),
        .q    (w_rd)
    );

    rom_FC2_BIASES #(
        .ADDR_WIDTH (O_W),
        .DATA_WIDTH (8),
        .DEPTH      (OUT_DIM),
        .MEM_FILE   (B_MEM_FILE)
    ) u_brom (
        .clk  (clk),
        .addr (o_q),
        .q    (b_rd)
    );

    // MAC stage sees ROM data for the address issued one cycle earlier
    assign act_s = $signed(word_q[mac_i_q[I_W-1:2]][{mac_i_q[1:0], 3'b000} +: 8]);
    assign prod  = act_s * $signed(w_rd);

    always_comb begin
        base = acc_q;
        if (mac_first_q) base = {{(ACC_W-8){b_rd[7]}}, b_rd};
        acc_d = base + {{(ACC_W-16){prod[15]}}, prod};
    end

    fc_argmax_tracker #(
        .W     (ACC_W),
        .IDX_W (O_W)
    ) u_argmax (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (emit),
        .first_i (mac_o_q == '0),
        .val_i   (acc_d),
        .idx_i   (mac_o_q),
        .idx_o   (max_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NWORDS; k++) word_q[k] <= '0;
        end else if (accept) begin
            word_q[wc_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_COLLECT;
            wc_q          <= '0;
            cnt_q         <= '0;
            i_q           <= '0;
            o_q           <= '0;
            mac_vld_q     <= 1'b0;
            mac_first_q   <= 1'b0;
            mac_last_q    <= 1'b0;
            mac_i_q       <= '0;
            mac_o_q       <= '0;
            acc_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            class_idx_q   <= '0;
            class_valid_q <= 1'b0;
            drop_err_q    <= 1'b0;
            in_ready_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wc_q          <= wc_d;
            cnt_q         <= cnt_d;
            i_q           <= i_d;
            o_q           <= o_d;
            mac_vld_q     <= issue;
            mac_first_q   <= (i_q == '0);
            mac_last_q    <= (i_q == I_W'(IN_DIM - 1));
            mac_i_q       <= i_q;
            mac_o_q       <= o_q;
            if (mac_vld_q) acc_q <= acc_d;
            if (emit) out_data_q <= acc_d;
            out_valid_q   <= emit;
            out_last_q    <= emit && (mac_o_q == O_W'(OUT_DIM - 1));
            class_valid_q <= done_d;
            if (done_d) class_idx_q <= max_idx;
            in_ready_q    <= (state_d == S_COLLECT);
            if (valid_in && !in_ready_q) drop_err_q <= 1'b1;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign class_idx   = class_idx_q;
    assign class_valid = class_valid_q;
    assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_layer4_fc2.sv
// Directed bench for layer4_fc2: table of ROM images and activation
// words with hand-computed logits, plus drop, gap and reset sequences.
module tb_layer4_fc2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic [3:0]  class_idx;
    logic        class_valid;
    logic        drop_err;

    always #5 clk = ~clk;

    layer4_fc2 #(
        .W_MEM_FILE (""),
        .B_MEM_FILE ("")
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .class_idx   (class_idx),
        .class_valid (class_valid),
        .drop_err    (drop_err)
    );

    typedef struct {
        int          mode;
        logic [31:0] word;
        int          exp [10];
        int          cls;
    } vec_t;

    vec_t vec [6];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [31:0] got_v [$];
    int          got_c [$];
    logic        got_l [$];
    int          cls_v [$];
    int          cls_c [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            got_v.push_back(out_data);
            got_c.push_back(cyc);
            got_l.push_back(out_last);
        end
        if (class_valid) begin
            cls_v.push_back(int'(class_idx));
            cls_c.push_back(cyc);
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, want);
    endtask

    function automatic logic [7:0] w_of(input int m, input int o, input int i);
        case (m)
            0:       return 8'h01;
            1:       return 8'h80;
            2:       return 8'h00;
            3:       return i[0] ? 8'hFF : 8'h01;
            default: return (o == 6) ? 8'h03 : 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] b_of(input int m, input int o);
        case (m)
            0:       return 8'(o);
            2:       return (o == 3) ? 8'h05 : 8'hFF;
            3:       return 8'(9 - o);
            default: return 8'h00;
        endcase
    endfunction

    task automatic load_rom(input int m);
        for (int o = 0; o < 10; o++) begin
            dut.u_brom.mem[4'(o)] = b_of(m, o);
            for (int i = 0; i < 32; i++)
                dut.u_wrom.mem[9'(o * 32 + i)] = w_of(m, o, i);
        end
    endtask

    task automatic send_frame(input logic [31:0] w, input int maxgap, output int acc);
        for (int k = 0; k < 8; k++) begin
            int g;
            int t;
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (g) @(negedge clk);
            t = 0;
            while (!in_ready && t < 1000) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("in_ready word%0d", k), 32'(in_ready), 32'd1);
            valid_in = 1'b1;
            in_data  = w;
            @(posedge clk);
            @(negedge clk);
            valid_in = 1'b0;
        end
        acc = cyc;
    endtask

    task automatic check_frame(input int vi, input int acc, input string tag);
        int t = 0;
        while (cls_v.size() == 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check({tag, " class_pulses"}, 32'(cls_v.size()), 32'd1);
        check({tag, " logit_count"}, 32'(got_v.size()), 32'd10);
        for (int o = 0; o < got_v.size() && o < 10; o++) begin
            check($sformatf("%s logit%0d", tag, o), got_v[o], 32'(vec[vi].exp[o]));
            check($sformatf("%s logit%0d_cycle", tag, o), 32'(got_c[o] - acc), 32'(33 + 32 * o));
            check($sformatf("%s last%0d", tag, o), 32'(got_l[o]), 32'(o == 9));
        end
        if (cls_v.size() > 0) begin
            check({tag, " class_idx"}, 32'(cls_v[0]), 32'(vec[vi].cls));
            check({tag, " class_cycle"}, 32'(cls_c[0] - acc), 32'd322);
        end
        got_v.delete();
        got_c.delete();
        got_l.delete();
        cls_v.delete();
        cls_c.delete();
        @(negedge clk);
    endtask

    initial begin
        int a;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        in_data  = '0;

        vec[0].mode = 0; vec[0].word = 32'h01010101; vec[0].cls = 9;
        vec[0].exp  = '{32, 33, 34, 35, 36, 37, 38, 39, 40, 41};
        vec[1].mode = 1; vec[1].word = 32'h80808080; vec[1].cls = 0;
        vec[1].exp  = '{524288, 524288, 524288, 524288, 524288,
                        524288, 524288, 524288, 524288, 524288};
        vec[2].mode = 2; vec[2].word = 32'h7F7F7F7F; vec[2].cls = 3;
        vec[2].exp  = '{-1, -1, -1, 5, -1, -1, -1, -1, -1, -1};
        vec[3].mode = 3; vec[3].word = 32'h01020304; vec[3].cls = 0;
        vec[3].exp  = '{25, 24, 23, 22, 21, 20, 19, 18, 17, 16};
        vec[4].mode = 4; vec[4].word = 32'h02020202; vec[4].cls = 6;
        vec[4].exp  = '{64, 64, 64, 64, 64, 64, 192, 64, 64, 64};
        vec[5].mode = 0; vec[5].word = 32'hFFFFFFFF; vec[5].cls = 9;
        vec[5].exp  = '{-32, -31, -30, -29, -28, -27, -26, -25, -24, -23};

        repeat (3) @(negedge clk);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_last", 32'(out_last), 32'd0);
        check("rst out_data", out_data, 32'd0);
        check("rst class_valid", 32'(class_valid), 32'd0);
        check("rst class_idx", 32'(class_idx), 32'd0);
        check("rst drop_err", 32'(drop_err), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after release", 32'(in_ready), 32'd1);

        for (int v = 0; v < 6; v++) begin
            load_rom(vec[v].mode);
            send_frame(vec[v].word, 0, a);
            check_frame(v, a, $sformatf("vec%0d", v));
        end

        load_rom(0);
        send_frame(vec[0].word, 0, a);
        repeat (40) @(negedge clk);
        check("in_ready compute c40", 32'(in_ready), 32'd0);
        check("drop_err before drop", 32'(drop_err), 32'd0);
        valid_in = 1'b1;
        in_data  = 32'hDEADBEEF;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        check("drop_err set", 32'(drop_err), 32'd1);
        repeat (150) @(negedge clk);
        check("in_ready compute c192", 32'(in_ready), 32'd0);
        check_frame(0, a, "drop");

        send_frame(vec[0].word, 5, a);
        check_frame(0, a, "gap1");
        send_frame(vec[5].word, 5, a);
        check_frame(5, a, "gap2");
        check("drop_err sticky", 32'(drop_err), 32'd1);

        send_frame(vec[0].word, 0, a);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst drop_err", 32'(drop_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        repeat (400) @(negedge clk);
        check("midrst logits seen", 32'(got_v.size()), 32'd3);
        check("midrst class pulses", 32'(cls_v.size()), 32'd0);
        check("midrst in_ready idle", 32'(in_ready), 32'd1);
        got_v.delete();
        got_c.delete();
        got_l.delete();
        cls_v.delete();
        cls_c.delete();

        load_rom(4);
        send_frame(vec[4].word, 0, a);
        check_frame(4, a, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
